// File: rtl/home_pkg.sv
// Shared definitions for the smart-appliance group: device indices,
// default scheduler sizing and the per-device power state.
package home_pkg;

  // Fixed device slots on the scheduler request bus
  localparam int DEV_FRIDGE = 0;
  localparam int DEV_OVEN   = 1;
  localparam int DEV_COFFEE = 2;
  localparam int DEV_WASHER = 3;
  localparam int DEV_DISH   = 4;

  // Default scheduler sizing
  localparam int DEF_N       = 5;
  localparam int DEF_W       = 4;
  localparam int DEF_BUDGET  = 10;
  localparam int DEF_MIN_OFF = 4;

  // Power state of one appliance as seen by the scheduler
  typedef enum logic [1:0] {
    OFF     = 2'd0,
    ON      = 2'd1,
    HOLDOFF = 2'd2
  } dev_state_e;

  // A granted device is ON; an ungranted one with a running hold-off
  // counter is HOLDOFF; anything else is OFF and may be admitted.
  function automatic dev_state_e dev_state(input logic granted,
                                           input logic holdoff_zero);
    dev_state_e st;
    if (granted)
      st = ON;
    else if (!holdoff_zero)
      st = HOLDOFF;
    else
      st = OFF;
    return st;
  endfunction

endpackage

// File: rtl/holdoff_timer.sv
// Per-device minimum off-time counter. Loading sets it to MIN_OFF;
// it then counts down to zero, and zero means the device may be
// admitted again. MIN_OFF of 0 makes the counter permanently zero.
module holdoff_timer #(
  parameter int MIN_OFF = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic ld,
  input  logic dec,
  output logic zero
);

  localparam int CW = (MIN_OFF > 0) ? $clog2(MIN_OFF + 1) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Next count: a release reloads, otherwise count down and stop at zero
  always_comb begin
    cnt_d = cnt_q;
    if (ld)
      cnt_d = CW'(MIN_OFF);
    else if (dec && (cnt_q != '0))
      cnt_d = cnt_q - 1'b1;
  end

  // Counter register; reset leaves no hold-off pending
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/appliance_load_scheduler.sv
// Power-budget scheduler for the appliance group. Devices are admitted
// one per cycle in round-robin order while the sum of their latched
// loads stays within BUDGET. Released devices sit out MIN_OFF cycles,
// and a shed request drops everything except the fridge.
module appliance_load_scheduler
  import home_pkg::*;
#(
  parameter int N       = DEF_N,
  parameter int W       = DEF_W,
  parameter int BUDGET  = DEF_BUDGET,
  parameter int MIN_OFF = DEF_MIN_OFF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N-1:0]           req,
  input  logic [N*W-1:0]         load,
  input  logic                   shed,
  output logic [N-1:0]           grant,
  output logic [W+$clog2(N)-1:0] used_load,
  output logic [N-1:0]           waiting
);

  localparam int SW = W + $clog2(N);
  // One spare bit so candidate + kept sum can be compared without wrap
  localparam int AW = SW + 1;
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  grant_q, grant_d;
  logic [SW-1:0] used_q, used_d;
  logic [N-1:0]  wait_q, wait_d;
  logic [PW-1:0] rr_q, rr_d;
  logic [W-1:0]  lat_q [N];
  logic [W-1:0]  lat_d [N];

  logic [N-1:0]  release_v;
  logic [N-1:0]  hold_zero;
  logic [N-1:0]  eligible;
  logic [N-1:0]  fits;
  logic [N-1:0]  admit;
  logic [AW-1:0] kept_sum;

  // Work out which ON devices drop this cycle and the load that remains
  always_comb begin
    release_v = '0;
    kept_sum  = '0;
    for (int i = 0; i < N; i++) begin
      // The fridge is never shed; a req drop and shed together is one release
      release_v[i] = grant_q[i] & (~req[i] | (shed & (i != DEV_FRIDGE)));
      if (grant_q[i] && !release_v[i])
        kept_sum = kept_sum + AW'(lat_q[i]);
    end
  end

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_dev
      logic [W-1:0] cand;

      assign cand = load[gi*W +: W];

      // Candidate fits against the load that survives this cycle's releases
      assign fits[gi] = ((kept_sum + AW'(cand)) <= AW'(BUDGET));

      // Requesting, not granted, hold-off expired; under shed only the fridge
      assign eligible[gi] = req[gi]
                          && (dev_state(grant_q[gi], hold_zero[gi]) == OFF)
                          && (!shed || (gi == DEV_FRIDGE));

      holdoff_timer #(
        .MIN_OFF(MIN_OFF)
      ) u_holdoff (
        .clk  (clk),
        .rst  (rst),
        .ld   (release_v[gi]),
        .dec  (1'b1),
        .zero (hold_zero[gi])
      );

      // Load is captured only at admission; changes while ON are ignored
      assign lat_d[gi] = admit[gi] ? cand : lat_q[gi];
    end
  endgenerate

  // Round-robin scan from rr_q; non-fitting devices are skipped, first fit wins
  always_comb begin
    int          idx_i;
    logic [PW-1:0] idx_p;
    logic        found;
    admit = '0;
    rr_d  = rr_q;
    found = 1'b0;
    idx_i = 0;
    idx_p = '0;
    for (int k = 0; k < N; k++) begin
      idx_i = int'(rr_q) + k;
      if (idx_i >= N)
        idx_i = idx_i - N;
      idx_p = PW'(idx_i);
      if (!found && eligible[idx_p] && fits[idx_p]) begin
        found        = 1'b1;
        admit[idx_p] = 1'b1;
        rr_d         = (idx_i == N - 1) ? '0 : PW'(idx_i + 1);
      end
    end
  end

  // Next grant vector, granted-load total and waiting flags
  always_comb begin
    grant_d = (grant_q & ~release_v) | admit;
    used_d  = '0;
    for (int i = 0; i < N; i++) begin
      if (grant_d[i])
        used_d = used_d + SW'(lat_d[i]);
    end
    wait_d = req & ~grant_d;
  end

  // Scheduler state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q <= '0;
      used_q  <= '0;
      wait_q  <= '0;
      rr_q    <= '0;
      for (int i = 0; i < N; i++)
        lat_q[i] <= '0;
    end else begin
      grant_q <= grant_d;
      used_q  <= used_d;
      wait_q  <= wait_d;
      rr_q    <= rr_d;
      for (int i = 0; i < N; i++)
        lat_q[i] <= lat_d[i];
    end
  end

  assign grant     = grant_q;
  assign used_load = used_q;
  assign waiting   = wait_q;

endmodule

// File: tb/tb_appliance_load_scheduler.sv
// Directed bench for appliance_load_scheduler (N=5, W=4, BUDGET=10, MIN_OFF=4):
// a vector table of single-cycle steps plus hand-written hold-off and
// mid-run reset sequences.
module tb_appliance_load_scheduler;

  localparam int N = 5;
  localparam int W = 4;

  logic           clk  = 1'b0;
  logic           rst  = 1'b0;
  logic [N-1:0]   req  = '0;
  logic [N*W-1:0] load = '0;
  logic           shed = 1'b0;
  logic [N-1:0]   grant;
  logic [6:0]     used_load;
  logic [N-1:0]   waiting;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  appliance_load_scheduler #(
    .N(5), .W(4), .BUDGET(10), .MIN_OFF(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .load      (load),
    .shed      (shed),
    .grant     (grant),
    .used_load (used_load),
    .waiting   (waiting)
  );

  typedef struct {
    bit         rst_first;
    logic [4:0] req;
    logic [19:0] ld;
    bit         shed;
    logic [4:0] g;
    logic [6:0] u;
    logic [4:0] w;
  } vec_t;

  vec_t vt[$];

  function automatic logic [19:0] ld5(int a, int b, int c, int d, int e);
    return {4'(e), 4'(d), 4'(c), 4'(b), 4'(a)};
  endfunction

  function automatic vec_t mk(bit r, logic [4:0] rq, logic [19:0] l, bit s,
                              logic [4:0] g, int u, logic [4:0] w);
    vec_t v;
    v.rst_first = r;
    v.req       = rq;
    v.ld        = l;
    v.shed      = s;
    v.g         = g;
    v.u         = 7'(u);
    v.w         = w;
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0h want %0h", name, idx, got, exp);
    end
  endtask

  task automatic check_all(string tag, int idx, logic [4:0] g, int u, logic [4:0] w);
    check({tag, ".grant"}, idx, 32'(grant), 32'(g));
    check({tag, ".used"}, idx, 32'(used_load), 32'(u));
    check({tag, ".waiting"}, idx, 32'(waiting), 32'(w));
  endtask

  task automatic do_reset();
    rst  = 1'b1;
    req  = '0;
    shed = 1'b0;
    load = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drive inputs, take one clock edge, sample just after it
  task automatic apply(logic [4:0] rq, logic [19:0] l, bit s);
    req  = rq;
    load = l;
    shed = s;
    @(posedge clk);
    #1;
    $display("%0t: req=%b shed=%b -> grant=%b used=%0d waiting=%b",
             $time, rq, s, grant, used_load, waiting);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    logic [19:0] l;

    // Reset state while reset is held
    #1 rst = 1'b1;
    #11;
    check_all("reset", 0, 5'b00000, 0, 5'b00000);
    @(negedge clk);
    rst = 1'b0;

    // A: single admission, budget-fit boundary, ignored load change
    vt.push_back(mk(1, 5'b00001, ld5(3,0,0,0,0), 0, 5'b00001, 3,  5'b00000));
    vt.push_back(mk(0, 5'b00011, ld5(3,8,0,0,0), 0, 5'b00001, 3,  5'b00010));
    vt.push_back(mk(0, 5'b00011, ld5(3,7,0,0,0), 0, 5'b00011, 10, 5'b00000));
    vt.push_back(mk(0, 5'b00011, ld5(9,7,0,0,0), 0, 5'b00011, 10, 5'b00000));
    vt.push_back(mk(0, 5'b00010, ld5(9,7,0,0,0), 0, 5'b00010, 7,  5'b00000));
    // B: round-robin order, skip on no-fit, same-edge reuse of freed load
    vt.push_back(mk(1, 5'b00110, ld5(0,6,5,0,0), 0, 5'b00010, 6,  5'b00100));
    vt.push_back(mk(0, 5'b00110, ld5(0,6,5,0,0), 0, 5'b00010, 6,  5'b00100));
    vt.push_back(mk(0, 5'b00100, ld5(0,6,5,0,0), 0, 5'b00100, 5,  5'b00000));
    // C: one grant per cycle
    vt.push_back(mk(1, 5'b11111, ld5(1,1,1,1,1), 0, 5'b00001, 1,  5'b11110));
    vt.push_back(mk(0, 5'b11111, ld5(1,1,1,1,1), 0, 5'b00011, 2,  5'b11100));
    vt.push_back(mk(0, 5'b11111, ld5(1,1,1,1,1), 0, 5'b00111, 3,  5'b11000));
    vt.push_back(mk(0, 5'b11111, ld5(1,1,1,1,1), 0, 5'b01111, 4,  5'b10000));
    vt.push_back(mk(0, 5'b11111, ld5(1,1,1,1,1), 0, 5'b11111, 5,  5'b00000));
    // D: zero load always fits, load above budget never granted
    vt.push_back(mk(1, 5'b01100, ld5(0,0,0,15,0), 0, 5'b00100, 0, 5'b01000));
    vt.push_back(mk(0, 5'b01100, ld5(0,0,0,15,0), 0, 5'b00100, 0, 5'b01000));
    vt.push_back(mk(0, 5'b01100, ld5(0,0,0,15,0), 0, 5'b00100, 0, 5'b01000));
    // E: fill to 9, shed keeps only the fridge, readmission after shed
    vt.push_back(mk(1, 5'b01101, ld5(2,0,3,4,0), 0, 5'b00001, 2,  5'b01100));
    vt.push_back(mk(0, 5'b01101, ld5(2,0,3,4,0), 0, 5'b00101, 5,  5'b01000));
    vt.push_back(mk(0, 5'b01101, ld5(2,0,3,4,0), 0, 5'b01101, 9,  5'b00000));
    vt.push_back(mk(0, 5'b01101, ld5(2,0,3,4,0), 1, 5'b00001, 2,  5'b01100));
    vt.push_back(mk(0, 5'b01101, ld5(2,0,3,4,0), 1, 5'b00001, 2,  5'b01100));
    vt.push_back(mk(0, 5'b01101, ld5(2,0,3,4,0), 1, 5'b00001, 2,  5'b01100));
    vt.push_back(mk(0, 5'b01101, ld5(2,0,3,4,0), 1, 5'b00001, 2,  5'b01100));
    vt.push_back(mk(0, 5'b01101, ld5(2,0,3,4,0), 1, 5'b00001, 2,  5'b01100));
    vt.push_back(mk(0, 5'b01101, ld5(2,0,3,4,0), 0, 5'b00101, 5,  5'b01000));
    vt.push_back(mk(0, 5'b01101, ld5(2,0,3,4,0), 0, 5'b01101, 9,  5'b00000));

    foreach (vt[i]) begin
      if (vt[i].rst_first)
        do_reset();
      apply(vt[i].req, vt[i].ld, vt[i].shed);
      check_all("vec", i, vt[i].g, int'(vt[i].u), vt[i].w);
    end

    // Hold-off: device 1 shed at edge t with req held; back at edge t+5
    do_reset();
    l = ld5(0,2,0,0,0);
    apply(5'b00010, l, 0);
    check_all("hold_on", 0, 5'b00010, 2, 5'b00000);
    apply(5'b00010, l, 1);
    check_all("hold_rel", 0, 5'b00000, 0, 5'b00010);
    for (int k = 1; k <= 4; k++) begin
      apply(5'b00010, l, 0);
      check("hold_wait.grant", k, 32'(grant), 32'(5'b00000));
    end
    apply(5'b00010, l, 0);
    check_all("hold_back", 5, 5'b00010, 2, 5'b00000);

    // Mid-run asynchronous reset with grant=01011
    do_reset();
    l = ld5(1,1,1,1,1);
    apply(5'b01011, l, 0);
    check("mr_fill.grant", 0, 32'(grant), 32'(5'b00001));
    apply(5'b01011, l, 0);
    check("mr_fill.grant", 1, 32'(grant), 32'(5'b00011));
    apply(5'b01011, l, 0);
    check_all("mr_fill", 2, 5'b01011, 3, 5'b00000);
    #2 rst = 1'b1;
    #1;
    check_all("mr_async", 0, 5'b00000, 0, 5'b00000);
    @(negedge clk);
    rst = 1'b0;
    apply(5'b01011, l, 0);
    check_all("mr_after", 0, 5'b00001, 1, 5'b01010);
    apply(5'b01011, l, 0);
    check_all("mr_after", 1, 5'b00011, 2, 5'b01000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
